// File: rtl/calc_pkg.sv
// Shared definitions for the calculator phase sequencer.
// Contents:
//   state_t          : sequencer state encoding (IDLE=0 .. FAULT=5)
//   ADDR_W_DEF       : default scratch RAM address width
//   DATA_W_DEF       : default scratch RAM word width
//   RAM_CTRL_W       : width of the RAM control part of the port bundle (write strobe)
//   ram_bus_w()      : total RAM port bundle width (strobe + address + data)
package calc_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 16;
  localparam int RAM_CTRL_W = 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PRE   = 3'd1,
    TURN  = 3'd2,
    CALC  = 3'd3,
    DONE  = 3'd4,
    FAULT = 3'd5
  } state_t;

  function automatic int ram_bus_w(input int addr_w, input int data_w);
    return RAM_CTRL_W + addr_w + data_w;
  endfunction

  localparam int RAM_BUS_W_DEF = RAM_CTRL_W + ADDR_W_DEF + DATA_W_DEF;

endpackage

// File: rtl/calc_ram_mux.sv
// Combinational scratch RAM port select.
// The RAM belongs to the preprocess writer while in PRE and to the FSM reader
// in TURN and CALC; in every other state the port is parked at address 0 with
// the write strobe low.
// Ports:
//   state        : current sequencer state
//   pre_wr_valid : preprocess has a word to write
//   pre_wr_addr  : preprocess write address
//   pre_wr_data  : preprocess write word
//   fsm_rd_addr  : FSM scan address
//   addr_oob     : a valid preprocess write targets an address >= DEPTH
//   ram_wr       : RAM write strobe
//   ram_addr     : RAM address
//   ram_din      : RAM write data
module calc_ram_mux
  import calc_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 256
) (
  input  state_t              state,
  input  logic                pre_wr_valid,
  input  logic [ADDR_W-1:0]   pre_wr_addr,
  input  logic [DATA_W-1:0]   pre_wr_data,
  input  logic [ADDR_W-1:0]   fsm_rd_addr,
  output logic                addr_oob,
  output logic                ram_wr,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [DATA_W-1:0]   ram_din
);

  // One extra bit so DEPTH == 2**ADDR_W is representable (never overflows).
  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(DEPTH);

  assign addr_oob = pre_wr_valid && ({1'b0, pre_wr_addr} >= DEPTH_LIM);

  always_comb begin
    // NOTE: every output gets a default first so no path through the case leaves it unassigned (no latch).
    ram_wr   = 1'b0;
    ram_addr = '0;
    ram_din  = '0;
    case (state)
      PRE: begin
        // Out-of-range writes are dropped in the same cycle they are presented.
        ram_wr   = pre_wr_valid && !addr_oob;
        ram_addr = pre_wr_addr;
        ram_din  = pre_wr_data;
      end
      // TURN pre-issues the first read so data is ready when FSM_En rises.
      TURN, CALC: ram_addr = fsm_rd_addr;
      default: ;
    endcase
  end

endmodule

// File: rtl/calc_sequencer.sv
// Registered phase controller for the calculator datapath.
// Sequences PreProcess, then Calculator_FSM, arbitrating the shared
// single-port scratch RAM, latching the result and pulsing Finish once.
// Optional build macro: CALC_SEQ_TIMEOUT_EN adds a per-phase watchdog that
// faults after TIMEOUT_CYC cycles in PRE or CALC.
// Ports:
//   Sysclk       : clock, rising edge
//   En           : asynchronous active-low reset
//   St           : start request (level)
//   Pre_Finish / Pre_Wr_Valid / Pre_Wr_Addr / Pre_Wr_Data : preprocess side
//   FSM_Rd_Addr / FSM_Finish / FSM_Fault / FSM_Result     : evaluation FSM side
//   Ram_Dout     : RAM read data (1-cycle read latency)
//   Pre_En, FSM_En : registered phase enables
//   Ram_Wr, Ram_Addr, Ram_Din : RAM port
//   FSM_Data     : RAM read data forwarded to the FSM
//   Result       : latched result
//   Finish       : one-cycle completion pulse
//   Fault        : sticky error flag, cleared by returning to IDLE
//   Busy         : high in PRE, TURN and CALC
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int DEPTH       = 256,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic              Sysclk,
  input  logic              En,
  input  logic              St,
  input  logic              Pre_Finish,
  input  logic              Pre_Wr_Valid,
  input  logic [ADDR_W-1:0] Pre_Wr_Addr,
  input  logic [DATA_W-1:0] Pre_Wr_Data,
  input  logic [ADDR_W-1:0] FSM_Rd_Addr,
  input  logic              FSM_Finish,
  input  logic              FSM_Fault,
  input  logic [DATA_W-1:0] FSM_Result,
  input  logic [DATA_W-1:0] Ram_Dout,
  output logic              Pre_En,
  output logic              FSM_En,
  output logic              Ram_Wr,
  output logic [ADDR_W-1:0] Ram_Addr,
  output logic [DATA_W-1:0] Ram_Din,
  output logic [DATA_W-1:0] FSM_Data,
  output logic [DATA_W-1:0] Result,
  output logic              Finish,
  output logic              Fault,
  output logic              Busy
);

  state_t state;
  logic   addr_oob;
  logic   timeout_hit;

  calc_ram_mux #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram_mux (
    .state        (state),
    .pre_wr_valid (Pre_Wr_Valid),
    .pre_wr_addr  (Pre_Wr_Addr),
    .pre_wr_data  (Pre_Wr_Data),
    .fsm_rd_addr  (FSM_Rd_Addr),
    .addr_oob     (addr_oob),
    .ram_wr       (Ram_Wr),
    .ram_addr     (Ram_Addr),
    .ram_din      (Ram_Din)
  );

  // Read data already carries the address issued on the previous cycle.
  assign FSM_Data = Ram_Dout;
  assign Busy     = (state == PRE) || (state == TURN) || (state == CALC);

`ifdef CALC_SEQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] phase_cnt;

  // IDLE and TURN are the only predecessors of PRE and CALC, so holding the
  // counter at zero there clears it on entry to either phase.
  always_ff @(posedge Sysclk or negedge En) begin
    if (!En) begin
      phase_cnt <= '0;
    end else if (state == PRE || state == CALC) begin
      phase_cnt <= phase_cnt + 1'b1;
    end else begin
      phase_cnt <= '0;
    end
  end

  // Fires on the TIMEOUT_CYC-th cycle spent in the phase.
  assign timeout_hit = (phase_cnt == CNT_LAST);
`else
  assign timeout_hit = 1'b0;
`endif

  // The scratch RAM is external and is deliberately left untouched by reset;
  // only control state and the result register are cleared.
  always_ff @(posedge Sysclk or negedge En) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!En) begin
      state  <= IDLE;
      Pre_En <= 1'b0;
      FSM_En <= 1'b0;
      Result <= '0;
      Finish <= 1'b0;
      Fault  <= 1'b0;
    end else begin
      Finish <= 1'b0;
      case (state)
        IDLE: begin
          if (St) begin
            state  <= PRE;
            Pre_En <= 1'b1;
          end
        end
        PRE: begin
          if (addr_oob) begin
            state  <= FAULT;
            Pre_En <= 1'b0;
            Fault  <= 1'b1;
          end else if (Pre_Finish) begin
            state  <= TURN;
            Pre_En <= 1'b0;
          end else if (timeout_hit) begin
            state  <= FAULT;
            Pre_En <= 1'b0;
            Fault  <= 1'b1;
          end
        end
        TURN: begin
          state  <= CALC;
          FSM_En <= 1'b1;
        end
        CALC: begin
          // A fault outranks a simultaneous finish: no result, no pulse.
          if (FSM_Fault || (!FSM_Finish && timeout_hit)) begin
            state  <= FAULT;
            FSM_En <= 1'b0;
            Fault  <= 1'b1;
          end else if (FSM_Finish) begin
            state  <= DONE;
            FSM_En <= 1'b0;
            Result <= FSM_Result;
            Finish <= 1'b1;
          end
        end
        DONE: begin
          if (!St) state <= IDLE;
        end
        FAULT: begin
          if (!St) begin
            state <= IDLE;
            Fault <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          Pre_En <= 1'b0;
          FSM_En <= 1'b0;
          Fault  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed testbench for calc_sequencer with a behavioural synchronous RAM
// (1-cycle read latency). DEPTH is set to 4 and TIMEOUT_CYC to 16.
module tb_calc_sequencer;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;

  logic              Sysclk;
  logic              En;
  logic              St;
  logic              Pre_Finish;
  logic              Pre_Wr_Valid;
  logic [ADDR_W-1:0] Pre_Wr_Addr;
  logic [DATA_W-1:0] Pre_Wr_Data;
  logic [ADDR_W-1:0] FSM_Rd_Addr;
  logic              FSM_Finish;
  logic              FSM_Fault;
  logic [DATA_W-1:0] FSM_Result;
  logic [DATA_W-1:0] Ram_Dout;
  logic              Pre_En;
  logic              FSM_En;
  logic              Ram_Wr;
  logic [ADDR_W-1:0] Ram_Addr;
  logic [DATA_W-1:0] Ram_Din;
  logic [DATA_W-1:0] FSM_Data;
  logic [DATA_W-1:0] Result;
  logic              Finish;
  logic              Fault;
  logic              Busy;

  int passed = 0;
  int total  = 0;

  logic [DATA_W-1:0] mem [256];

  calc_sequencer #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .DEPTH       (4),
    .TIMEOUT_CYC (16)
  ) dut (
    .Sysclk       (Sysclk),
    .En           (En),
    .St           (St),
    .Pre_Finish   (Pre_Finish),
    .Pre_Wr_Valid (Pre_Wr_Valid),
    .Pre_Wr_Addr  (Pre_Wr_Addr),
    .Pre_Wr_Data  (Pre_Wr_Data),
    .FSM_Rd_Addr  (FSM_Rd_Addr),
    .FSM_Finish   (FSM_Finish),
    .FSM_Fault    (FSM_Fault),
    .FSM_Result   (FSM_Result),
    .Ram_Dout     (Ram_Dout),
    .Pre_En       (Pre_En),
    .FSM_En       (FSM_En),
    .Ram_Wr       (Ram_Wr),
    .Ram_Addr     (Ram_Addr),
    .Ram_Din      (Ram_Din),
    .FSM_Data     (FSM_Data),
    .Result       (Result),
    .Finish       (Finish),
    .Fault        (Fault),
    .Busy         (Busy)
  );

  initial Sysclk = 1'b0;
  always #5 Sysclk = ~Sysclk;

  // Synchronous single-port RAM model, read-before-write, 1-cycle latency.
  always @(posedge Sysclk) begin
    if (Ram_Wr) mem[Ram_Addr] <= Ram_Din;
    Ram_Dout <= mem[Ram_Addr];
  end

  task automatic step();
    @(posedge Sysclk);
    #1;
  endtask

  task automatic clear_inputs();
    St = 1'b0; Pre_Finish = 1'b0; Pre_Wr_Valid = 1'b0; Pre_Wr_Addr = '0;
    Pre_Wr_Data = '0; FSM_Rd_Addr = '0; FSM_Finish = 1'b0; FSM_Fault = 1'b0;
    FSM_Result = '0;
  endtask

  // Holds reset across two edges and releases it mid-cycle.
  task automatic do_reset();
    En = 1'b0;
    clear_inputs();
    step();
    step();
    #2 En = 1'b1;
  endtask

  // IDLE -> PRE -> TURN -> CALC with no preprocess writes.
  task automatic go_calc();
    St = 1'b1;
    step();
    Pre_Finish = 1'b1;
    step();
    Pre_Finish = 1'b0;
    step();
  endtask

  task automatic test_reset();
    En = 1'b0;
    clear_inputs();
    #3;
    total++; if ({Pre_En, FSM_En, Ram_Wr, Finish, Fault, Busy} !== 6'b0) $display("FAIL reset_flags got=%b exp=000000", {Pre_En, FSM_En, Ram_Wr, Finish, Fault, Busy}); else passed++;
    total++; if (Result !== 16'h0000) $display("FAIL reset_result got=%h exp=0000", Result); else passed++;
    total++; if (Ram_Addr !== 8'h00) $display("FAIL reset_ram_addr got=%h exp=00", Ram_Addr); else passed++;
    step();
    #2 En = 1'b1;
  endtask

  task automatic test_normal();
    St = 1'b1;
    step();
    total++; if (Pre_En !== 1'b1) $display("FAIL norm_pre_en got=%b exp=1", Pre_En); else passed++;
    total++; if (Busy !== 1'b1) $display("FAIL norm_busy_pre got=%b exp=1", Busy); else passed++;
    total++; if (Ram_Wr !== 1'b0) $display("FAIL norm_wr_idle_cycle got=%b exp=0", Ram_Wr); else passed++;
    Pre_Wr_Valid = 1'b1; Pre_Wr_Addr = 8'd0; Pre_Wr_Data = 16'h0031;
    #1;
    total++; if ({Ram_Wr, Ram_Addr, Ram_Din} !== {1'b1, 8'd0, 16'h0031}) $display("FAIL norm_wr0 got=%b/%h/%h exp=1/00/0031", Ram_Wr, Ram_Addr, Ram_Din); else passed++;
    step();
    Pre_Wr_Valid = 1'b0; Pre_Wr_Addr = 8'd1;
    #1;
    total++; if (Ram_Wr !== 1'b0) $display("FAIL norm_wr_gap got=%b exp=0", Ram_Wr); else passed++;
    step();
    Pre_Wr_Valid = 1'b1; Pre_Wr_Addr = 8'd1; Pre_Wr_Data = 16'h002B;
    step();
    Pre_Wr_Addr = 8'd2; Pre_Wr_Data = 16'h0032; Pre_Finish = 1'b1;
    #1;
    total++; if ({Ram_Wr, Ram_Addr, Ram_Din} !== {1'b1, 8'd2, 16'h0032}) $display("FAIL norm_wr2_with_finish got=%b/%h/%h exp=1/02/0032", Ram_Wr, Ram_Addr, Ram_Din); else passed++;
    step();
    // TURN
    Pre_Wr_Valid = 1'b0; Pre_Finish = 1'b0; FSM_Rd_Addr = 8'd0;
    #1;
    total++; if ({Pre_En, FSM_En, Ram_Wr, Busy} !== 4'b0001) $display("FAIL norm_turn got=%b exp=0001", {Pre_En, FSM_En, Ram_Wr, Busy}); else passed++;
    step();
    // CALC, first cycle: word 0 already valid
    total++; if (FSM_En !== 1'b1) $display("FAIL norm_fsm_en got=%b exp=1", FSM_En); else passed++;
    total++; if (FSM_Data !== 16'h0031) $display("FAIL norm_rd0 got=%h exp=0031", FSM_Data); else passed++;
    FSM_Rd_Addr = 8'd1;
    step();
    total++; if (FSM_Data !== 16'h002B) $display("FAIL norm_rd1 got=%h exp=002B", FSM_Data); else passed++;
    FSM_Rd_Addr = 8'd2;
    step();
    total++; if (FSM_Data !== 16'h0032) $display("FAIL norm_rd2 got=%h exp=0032", FSM_Data); else passed++;
    FSM_Finish = 1'b1; FSM_Result = 16'h0003;
    #1;
    total++; if (Finish !== 1'b0) $display("FAIL norm_finish_early got=%b exp=0", Finish); else passed++;
    step();
    total++; if ({Finish, FSM_En, Busy} !== 3'b100) $display("FAIL norm_done_flags got=%b exp=100", {Finish, FSM_En, Busy}); else passed++;
    total++; if (Result !== 16'h0003) $display("FAIL norm_result got=%h exp=0003", Result); else passed++;
    FSM_Finish = 1'b0; FSM_Result = 16'hFFFF;
    step();
    total++; if (Finish !== 1'b0) $display("FAIL norm_finish_one_cycle got=%b exp=0", Finish); else passed++;
    step();
    total++; if ({Pre_En, Result} !== {1'b0, 16'h0003}) $display("FAIL norm_done_hold got=%b/%h exp=0/0003", Pre_En, Result); else passed++;
    St = 1'b0;
    step();
  endtask

  task automatic test_read_latency();
    mem[5] = 16'hA5A5;
    mem[6] = 16'h5A5A;
    go_calc();
    FSM_Rd_Addr = 8'd5;
    #1;
    total++; if (Ram_Addr !== 8'd5) $display("FAIL lat_addr got=%h exp=05", Ram_Addr); else passed++;
    step();
    FSM_Rd_Addr = 8'd6;
    #1;
    total++; if (FSM_Data !== 16'hA5A5) $display("FAIL lat_data_n1 got=%h exp=A5A5", FSM_Data); else passed++;
    step();
    total++; if (FSM_Data !== 16'h5A5A) $display("FAIL lat_data_n2 got=%h exp=5A5A", FSM_Data); else passed++;
    FSM_Finish = 1'b1; FSM_Result = 16'h1234;
    step();
    total++; if ({Finish, Result} !== {1'b1, 16'h1234}) $display("FAIL lat_result got=%b/%h exp=1/1234", Finish, Result); else passed++;
    FSM_Finish = 1'b0; St = 1'b0;
    step();
  endtask

  task automatic test_overflow();
    St = 1'b1;
    step();
    Pre_Wr_Valid = 1'b1; Pre_Wr_Addr = 8'd3; Pre_Wr_Data = 16'h0777;
    #1;
    total++; if (Ram_Wr !== 1'b1) $display("FAIL ovf_last_addr_wr got=%b exp=1", Ram_Wr); else passed++;
    step();
    Pre_Wr_Addr = 8'd4; Pre_Wr_Data = 16'h0888;
    #1;
    total++; if (Ram_Wr !== 1'b0) $display("FAIL ovf_suppress got=%b exp=0", Ram_Wr); else passed++;
    step();
    total++; if ({Fault, Finish, Pre_En, Busy, Ram_Wr} !== 5'b10000) $display("FAIL ovf_fault got=%b exp=10000", {Fault, Finish, Pre_En, Busy, Ram_Wr}); else passed++;
    step();
    total++; if ({Fault, Finish} !== 2'b10) $display("FAIL ovf_sticky got=%b exp=10", {Fault, Finish}); else passed++;
    Pre_Wr_Valid = 1'b0; St = 1'b0;
    step();
    total++; if (Fault !== 1'b0) $display("FAIL ovf_clear got=%b exp=0", Fault); else passed++;
    St = 1'b1;
    step();
    total++; if (Pre_En !== 1'b1) $display("FAIL ovf_restart got=%b exp=1", Pre_En); else passed++;
    do_reset();
  endtask

  task automatic test_fault_priority();
    go_calc();
    FSM_Fault = 1'b1; FSM_Finish = 1'b1; FSM_Result = 16'hBEEF;
    step();
    total++; if ({Fault, Finish, FSM_En} !== 3'b100) $display("FAIL prio_flags got=%b exp=100", {Fault, Finish, FSM_En}); else passed++;
    total++; if (Result !== 16'h0000) $display("FAIL prio_result got=%h exp=0000", Result); else passed++;
    FSM_Fault = 1'b0; FSM_Finish = 1'b0;
    step();
    total++; if ({Fault, Finish} !== 2'b10) $display("FAIL prio_no_pulse got=%b exp=10", {Fault, Finish}); else passed++;
    St = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    St = 1'b1;
    step();
    Pre_Wr_Valid = 1'b1; Pre_Wr_Addr = 8'd1; Pre_Wr_Data = 16'h0999;
    #1;
    total++; if ({Pre_En, Ram_Wr, Busy} !== 3'b111) $display("FAIL rstmid_before got=%b exp=111", {Pre_En, Ram_Wr, Busy}); else passed++;
    #1 En = 1'b0;
    #1;
    total++; if ({Pre_En, Ram_Wr, Busy} !== 3'b000) $display("FAIL rstmid_async got=%b exp=000", {Pre_En, Ram_Wr, Busy}); else passed++;
    Pre_Wr_Valid = 1'b0;
    step();
    total++; if (Pre_En !== 1'b0) $display("FAIL rstmid_held got=%b exp=0", Pre_En); else passed++;
    #2 En = 1'b1;
    step();
    total++; if ({Pre_En, Busy} !== 2'b11) $display("FAIL rstmid_restart got=%b exp=11", {Pre_En, Busy}); else passed++;
    do_reset();
  endtask

  task automatic test_timeout();
    go_calc();
`ifdef CALC_SEQ_TIMEOUT_EN
    repeat (15) step();
    total++; if (Fault !== 1'b0) $display("FAIL tmo_early got=%b exp=0", Fault); else passed++;
    step();
    total++; if ({Fault, FSM_En, Finish} !== 3'b100) $display("FAIL tmo_fault got=%b exp=100", {Fault, FSM_En, Finish}); else passed++;
`else
    repeat (40) step();
    total++; if ({Fault, FSM_En, Busy} !== 3'b011) $display("FAIL tmo_wait got=%b exp=011", {Fault, FSM_En, Busy}); else passed++;
`endif
    do_reset();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    Ram_Dout = '0;
    test_reset();
    test_normal();
    test_read_latency();
    test_overflow();
    test_fault_priority();
    test_reset_mid();
    test_timeout();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/calc_sequencer.md
Name: calc_sequencer

Overview:
- Registered phase controller for the calculator datapath.
- Sequences the preprocess stage and then the evaluation FSM, and owns the single-port scratch RAM (Data_Ram B) shared between them.
- Muxes the RAM between the preprocess writer and the FSM reader, latches the result, and issues a one-cycle Finish pulse.
- Sits between the calculator top-level pins and the PreProcess / Calculator_FSM / Data_Ram instances, replacing combinational phase control.

Parameters:
- ADDR_W, 8, scratch RAM address width.
- DATA_W, 16, scratch RAM word width and result width.
- DEPTH, 256, usable RAM words; a write address >= DEPTH is an overflow.
- TIMEOUT_CYC, 4096, watchdog limit in cycles per phase (used only with the optional feature).

Ports:
- Sysclk  in  1  system clock, rising edge.
- En  in  1  asynchronous active-low reset; low forces every register to its reset value immediately.
- St  in  1  start request, level; must be high in IDLE to begin.
- Pre_Finish  in  1  preprocess done, level.
- Pre_Wr_Valid  in  1  preprocess has a word to write this cycle.
- Pre_Wr_Addr  in  ADDR_W  preprocess write pointer.
- Pre_Wr_Data  in  DATA_W  preprocess output word.
- FSM_Rd_Addr  in  ADDR_W  FSM scan pointer.
- FSM_Finish  in  1  FSM done, level.
- FSM_Fault  in  1  FSM syntax/arith fault.
- FSM_Result  in  DATA_W  FSM result.
- Ram_Dout  in  DATA_W  RAM read data; synchronous read, 1-cycle latency.
- Pre_En  out  1  enable to PreProcess.
- FSM_En  out  1  enable to Calculator_FSM.
- Ram_Wr  out  1  RAM write strobe.
- Ram_Addr  out  ADDR_W  RAM address.
- Ram_Din  out  DATA_W  RAM write data.
- FSM_Data  out  DATA_W  word presented to the FSM; equals Ram_Dout.
- Result  out  DATA_W  latched result.
- Finish  out  1  one-cycle completion pulse.
- Fault  out  1  sticky error flag.
- Busy  out  1  high in PRE, TURN and CALC.

Behaviour:
- States: IDLE, PRE, TURN, CALC, DONE, FAULT, held in a registered state vector.
- Reset values: state=IDLE; all outputs 0, including Result.
- IDLE:
  - Pre_En=0, FSM_En=0, Ram_Wr=0, Ram_Addr=0.
  - St=1 -> PRE next edge.
- PRE:
  - Pre_En=1 (registered, first high in the first PRE cycle).
  - Ram_Wr = Pre_Wr_Valid; Ram_Addr = Pre_Wr_Addr; Ram_Din = Pre_Wr_Data. These are combinational pass-through, so writes have zero added latency.
  - Pre_Wr_Valid=1 with Pre_Wr_Addr >= DEPTH -> Ram_Wr suppressed that cycle -> FAULT.
  - Pre_Finish=1 -> TURN. A write presented in the same cycle as Pre_Finish is still performed.
- TURN: exactly one cycle; Pre_En=0, FSM_En=0, Ram_Wr=0, Ram_Addr = FSM_Rd_Addr. This pre-issues the first read so that data is valid when FSM_En rises.
- CALC:
  - FSM_En=1, Ram_Wr=0, Ram_Addr = FSM_Rd_Addr (combinational).
  - FSM_Data = Ram_Dout, i.e. data for the address issued the previous cycle.
  - FSM_Fault=1 -> FAULT; it has priority over FSM_Finish in the same cycle.
  - Else FSM_Finish=1 -> Result <= FSM_Result, Finish=1 for exactly one cycle -> DONE.
- DONE:
  - All enables 0; Result held.
  - St=0 -> IDLE. St held high keeps the block in DONE; there is no auto-restart.
- FAULT:
  - Fault=1, enables 0, Result unchanged.
  - St=0 -> IDLE, which clears Fault.
- St changes outside IDLE/DONE/FAULT are ignored.
- En low at any time, including mid-write, forces IDLE asynchronously. The RAM contents are not cleared.
- Finish is never asserted in FAULT and never for more than 1 cycle per run.

Optional Feature:
- Macro: CALC_SEQ_TIMEOUT_EN.
- Defined:
  - A phase counter clears on entry to PRE and CALC and increments each cycle in those states.
  - Reaching TIMEOUT_CYC -> FAULT.
  - Counter width is $clog2(TIMEOUT_CYC+1).
- Undefined: no counter; PRE and CALC wait indefinitely.

Decomposition:
- Shared package calc_pkg:
  - state enum/localparams (IDLE=0, PRE=1, TURN=2, CALC=3, DONE=4, FAULT=5);
  - ADDR_W/DATA_W defaults;
  - the RAM port bundle width constants.
- One natural sub-module, calc_ram_mux: the combinational RAM port select driven by the state.
- FSM, result latch and watchdog stay in calc_sequencer.

Test Plan:
- Normal run: St=1 in IDLE.
  - Preprocess writes 3 words to 0..2 (0x0031, 0x002B, 0x0032), then Pre_Finish.
  - FSM reads 0..2, then FSM_Finish with FSM_Result=0x0003.
  - Required: Pre_En high next edge; Ram_Wr high only on valid cycles; one TURN cycle with Ram_Wr=0; Result=0x0003; Finish high exactly 1 cycle; DONE.
- Read latency: in CALC, FSM_Rd_Addr=5 on cycle n.
  - Required: Ram_Addr=5 on cycle n; FSM_Data = word 5 on cycle n+1.
- Overflow: DEPTH=4, Pre_Wr_Addr=4 with Pre_Wr_Valid=1.
  - Required: Ram_Wr=0 that cycle; Fault=1 next edge; Finish never asserted; St=0 returns to IDLE with Fault=0.
- Fault priority: FSM_Fault=1 and FSM_Finish=1 in the same cycle.
  - Required: FAULT state; Result stays 0; no Finish pulse.
- Reset mid-operation: En driven low in the middle of PRE.
  - Required: Pre_En, Ram_Wr and Busy drop without waiting for a clock edge; state=IDLE; with St held high after En returns, PRE starts on the next edge.
- Timeout (CALC_SEQ_TIMEOUT_EN, TIMEOUT_CYC=16): enter CALC and never assert FSM_Finish.
  - Required: Fault=1 after 16 CALC cycles; without the macro, the block remains in CALC.
